// File: rtl/uart_frame_parser_if.sv
// Byte-stream and control-strobe bundle between the UART receiver, the frame
// parser and the matrix-vector array's FIFO / L / N register inputs.
interface uart_frame_parser_if #(
    parameter int NUM_ROW_FIFOS = 4
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             data_out;
    logic                   L_register_enable;
    logic                   N_register_enable;
    logic [NUM_ROW_FIFOS:0] push_FIFO;
    logic                   start_op;
    logic                   frame_error;
    logic                   busy;

    modport master (
        output rx_data, rx_valid,
        input  data_out, L_register_enable, N_register_enable, push_FIFO,
               start_op, frame_error, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output data_out, L_register_enable, N_register_enable, push_FIFO,
               start_op, frame_error, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Host command frame parser: FE, L, CMD, payload, EF. Drives L/N register
// enables, row/vector FIFO pushes and start requests; flags malformed frames.
//
// state     | meaning
// S_IDLE    | waiting for start byte 0xFE
// S_LEN     | next byte is the length L
// S_CMD     | next byte is the command, checked against L and n_reg
// S_PAYLOAD | consuming L-1 payload bytes
// S_END     | next byte must be 0xEF
module uart_frame_parser #(
    parameter int MAX_N         = 8,
    parameter int NUM_ROW_FIFOS = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_parser_if.slave  bus
);
    localparam int NW = $clog2(MAX_N + 1);
    localparam int CW = $clog2(MAX_N * MAX_N + 2);
    localparam int RW = (NUM_ROW_FIFOS > 1) ? $clog2(NUM_ROW_FIFOS) : 1;

    localparam logic [7:0] SOF_BYTE  = 8'hFE;
    localparam logic [7:0] EOF_BYTE  = 8'hEF;
    localparam logic [7:0] CMD_SET_N = 8'h01;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_MAT   = 8'h04;
    localparam logic [7:0] CMD_VEC   = 8'h05;
    localparam logic [7:0] MAX_N_B   = 8'(MAX_N);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_END} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [CW-1:0]          remain_q, remain_d;
    logic [NW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [NW-1:0]          n_q, n_d;
    logic [7:0]             n_pend_q, n_pend_d;
    logic                   n_ok_q, n_ok_d;
    logic [7:0]             data_q, data_d;
    logic                   len_en_q, len_en_d;
    logic                   n_en_q, n_en_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   busy_q;
    logic [NUM_ROW_FIFOS:0] push_q, push_d;

    logic [7:0] n_ext;
    logic [7:0] len_mat;
    logic [7:0] len_vec;
    logic       len_ok;

    assign n_ext   = 8'(n_q);
    assign len_mat = n_ext * n_ext + 8'd1;
    assign len_vec = n_ext + 8'd1;

    // Length / N legality of the incoming byte, used only in S_CMD.
    always_comb begin
        len_ok = 1'b0;
        case (bus.rx_data)
            CMD_SET_N: len_ok = (len_q == 8'd2);
            CMD_START: len_ok = (n_q != '0) && (len_q == 8'd1);
            CMD_MAT:   len_ok = (n_q != '0) && (len_q == len_mat);
            CMD_VEC:   len_ok = (n_q != '0) && (len_q == len_vec);
            default:   len_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cmd_d    = cmd_q;
        remain_d = remain_q;
        col_d    = col_q;
        row_d    = row_q;
        n_d      = n_q;
        n_pend_d = n_pend_q;
        n_ok_d   = n_ok_q;
        data_d   = data_q;
        len_en_d = 1'b0;
        n_en_d   = 1'b0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        push_d   = '0;
        if (bus.rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == SOF_BYTE) state_d = S_LEN;
                end
                S_LEN: begin
                    len_d    = bus.rx_data;
                    data_d   = bus.rx_data;
                    len_en_d = 1'b1;
                    if (bus.rx_data == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_d    = bus.rx_data;
                    col_d    = '0;
                    row_d    = '0;
                    n_ok_d   = 1'b0;
                    remain_d = CW'(len_q - 8'd1);
                    if (!len_ok) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (len_q == 8'd1) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    case (cmd_q)
                        CMD_MAT: begin
                            push_d[row_q] = 1'b1;
                            data_d        = bus.rx_data;
                            // Column wrap advances the row; row index is kept modulo the FIFO count.
                            if (col_q == n_q - NW'(1)) begin
                                col_d = '0;
                                row_d = (row_q == RW'(NUM_ROW_FIFOS - 1)) ? '0 : row_q + RW'(1);
                            end else begin
                                col_d = col_q + NW'(1);
                            end
                        end
                        CMD_VEC: begin
                            push_d[NUM_ROW_FIFOS] = 1'b1;
                            data_d                = bus.rx_data;
                        end
                        CMD_SET_N: begin
                            n_pend_d = bus.rx_data;
                            n_ok_d   = (bus.rx_data != 8'd0) && (bus.rx_data <= MAX_N_B);
                        end
                        default: ;
                    endcase
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) state_d = S_END;
                end
                S_END: begin
                    state_d = S_IDLE;
                    if (bus.rx_data != EOF_BYTE) begin
                        err_d = 1'b1;
                    end else if (cmd_q == CMD_START) begin
                        start_d = 1'b1;
                    end else if (cmd_q == CMD_SET_N) begin
                        if (n_ok_q) begin
                            n_en_d = 1'b1;
                            data_d = n_pend_q;
                            n_d    = NW'(n_pend_q);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cmd_q    <= '0;
            remain_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            n_q      <= '0;
            n_pend_q <= '0;
            n_ok_q   <= 1'b0;
            data_q   <= '0;
            len_en_q <= 1'b0;
            n_en_q   <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            push_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cmd_q    <= cmd_d;
            remain_q <= remain_d;
            col_q    <= col_d;
            row_q    <= row_d;
            n_q      <= n_d;
            n_pend_q <= n_pend_d;
            n_ok_q   <= n_ok_d;
            data_q   <= data_d;
            len_en_q <= len_en_d;
            n_en_q   <= n_en_d;
            start_q  <= start_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
            push_q   <= push_d;
        end
    end

    assign bus.data_out          = data_q;
    assign bus.L_register_enable = len_en_q;
    assign bus.N_register_enable = n_en_q;
    assign bus.push_FIFO         = push_q;
    assign bus.start_op          = start_q;
    assign bus.frame_error       = err_q;
    assign bus.busy              = busy_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Stream-level bench for uart_frame_parser: directed frames plus random frame
// traffic, checked against a frame-position reference model.
module tb_uart_frame_parser;
    logic clk;
    logic rst_n;

    uart_frame_parser_if #(.NUM_ROW_FIFOS(4)) bus ();

    uart_frame_parser #(.MAX_N(8), .NUM_ROW_FIFOS(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position of the current byte within the frame.
    bit         in_frame;
    int         pos;
    int         m_len;
    int         m_cmd;
    int         m_n;
    int         m_val;
    logic [7:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_len(input int cmd);
        case (cmd)
            1:       return 2;
            3:       return (m_n != 0) ? 1 : -1;
            4:       return (m_n != 0) ? m_n * m_n + 1 : -1;
            5:       return (m_n != 0) ? m_n + 1 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        in_frame = 1'b0;
        pos      = 0;
        m_len    = 0;
        m_cmd    = 0;
        m_n      = 0;
        m_val    = 0;
        m_data   = 8'h00;
    endtask

    function automatic logic [9:0] observed();
        return {bus.L_register_enable, bus.N_register_enable, bus.push_FIFO,
                bus.start_op, bus.frame_error, bus.busy};
    endfunction

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic send(input logic [7:0] b);
        logic       len_e, n_e, st_e, er_e;
        logic [4:0] pu;
        int         k;
        len_e = 0; n_e = 0; st_e = 0; er_e = 0; pu = '0;
        if (!in_frame) begin
            if (b == 8'hFE) begin
                in_frame = 1'b1;
                pos      = 0;
            end
        end else begin
            pos++;
            if (pos == 1) begin
                m_len  = b;
                len_e  = 1'b1;
                m_data = b;
                if (b == 8'h00) begin
                    er_e     = 1'b1;
                    in_frame = 1'b0;
                end
            end else if (pos == 2) begin
                m_cmd = b;
                if (exp_len(m_cmd) != m_len) begin
                    er_e     = 1'b1;
                    in_frame = 1'b0;
                end
            end else if (pos <= m_len + 1) begin
                k = pos - 3;
                if (m_cmd == 4) begin
                    pu[(k / m_n) % 4] = 1'b1;
                    m_data = b;
                end else if (m_cmd == 5) begin
                    pu[4]  = 1'b1;
                    m_data = b;
                end else if (m_cmd == 1) begin
                    m_val = b;
                end
            end else begin
                in_frame = 1'b0;
                if (b != 8'hEF) begin
                    er_e = 1'b1;
                end else if (m_cmd == 3) begin
                    st_e = 1'b1;
                end else if (m_cmd == 1) begin
                    if (m_val >= 1 && m_val <= 8) begin
                        n_e    = 1'b1;
                        m_data = 8'(m_val);
                        m_n    = m_val;
                    end else begin
                        er_e = 1'b1;
                    end
                end
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk($sformatf("ctl_%02h", b), 32'(observed()),
            32'({len_e, n_e, pu, st_e, er_e, in_frame}));
        chk($sformatf("data_%02h", b), 32'(bus.data_out), 32'(m_data));
    endtask

    task automatic gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.rx_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("gap_ctl", 32'(observed()), 32'({9'b0, in_frame}));
        end
    endtask

    task automatic send_q(input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) begin
            send(q[i]);
            if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(observed()), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_frame();
        logic [7:0] q[$];
        int         kind, len, cmd, npay;
        logic [7:0] b;
        q = {};
        for (int i = 0; i < $urandom_range(0, 2); i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hFE) b = 8'h00;
            q.push_back(b);
        end
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1: begin cmd = 1; len = 2; end
            2:    begin cmd = 3; len = 1; end
            3, 4: begin cmd = 4; len = m_n * m_n + 1; end
            5, 6: begin cmd = 5; len = m_n + 1; end
            7:    begin cmd = $urandom_range(3, 5); len = $urandom_range(0, 10); end
            8:    begin cmd = 6 + $urandom_range(0, 200); len = $urandom_range(1, 4); end
            default: begin cmd = 1; len = $urandom_range(1, 3); end
        endcase
        q.push_back(8'hFE);
        q.push_back(8'(len));
        q.push_back(8'(cmd));
        npay = (len > 0) ? len - 1 : 0;
        for (int i = 0; i < npay; i++) begin
            if (cmd == 1)
                b = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(1, 8));
            else
                b = 8'($urandom_range(0, 255));
            q.push_back(b);
        end
        q.push_back(($urandom_range(0, 7) == 0) ? 8'hAA : 8'hEF);
        send_q(q, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'(observed()), 32'd0);
        chk("reset_data", 32'(bus.data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_q('{8'h00, 8'hEF, 8'h55}, 1'b0);
        gap(1);
        send_q('{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF}, 1'b0);
        chk("n_set_3", 32'(m_n), 32'd3);
        send_q('{8'hFE, 8'h0A, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
                 8'h17, 8'h18, 8'h19, 8'hEF}, 1'b0);
        send_q('{8'hFE, 8'h04, 8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hEF,
                 8'hFE, 8'h01, 8'h03, 8'hEF}, 1'b0);
        send_q('{8'hFE, 8'h03, 8'h01, 8'h03, 8'hEF}, 1'b0);
        send_q('{8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF}, 1'b0);
        send_q('{8'hFE, 8'h01, 8'h03, 8'hAA}, 1'b0);
        gap(2);

        send_q('{8'hFE, 8'h0A, 8'h04, 8'h21, 8'h22, 8'hFE, 8'h24, 8'h25}, 1'b0);
        do_reset();
        send_q('{8'hFE, 8'h01, 8'h03, 8'hEF}, 1'b0);
        gap(1);

        for (int f = 0; f < 60; f++) rand_frame();
        gap(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

- Sits directly upstream of the input FIFOs and the L/N configuration registers of the matrix-vector processor array.
- Consumes bytes from the UART receiver and parses host command frames.
- Drives the UART control signals: L/N register enables, push strobes for FIFO1–FIFO4 (matrix rows) and FIFO5 (vector), and a start request for the processor control stage.
- Validates framing and length, and reports malformed frames.

## Interface
- MAX_N, 8, largest accepted matrix dimension (valid N is 1..MAX_N).
- NUM_ROW_FIFOS, 4, number of matrix-row FIFOs; row r goes to FIFO (r mod 4)+1.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- data_out  output  8  registered copy of the accepted byte; accompanies every enable/push.
- L_register_enable  output  1  one-cycle pulse; data_out holds the frame length L.
- N_register_enable  output  1  one-cycle pulse; data_out holds the new N.
- push_FIFO  output  5  one-hot push strobe, bit0 = FIFO1 … bit4 = FIFO5.
- start_op  output  1  one-cycle pulse requesting a matrix-vector operation.
- frame_error  output  1  one-cycle pulse on a malformed frame.
- busy  output  1  high from start byte accepted until the parser returns to IDLE.

## Operation
- Frame format: 0xFE, L, CMD, payload (L−1 bytes), 0xEF. L counts CMD plus payload.
- States: IDLE → LEN → CMD → PAYLOAD → END → IDLE. Each transition happens only on rx_valid.
- IDLE:
  - 0xFE goes to LEN.
  - Any other byte is ignored, with no error.
- LEN:
  - Pulses L_register_enable.
  - L = 0 raises frame_error and returns to IDLE.
- CMD:
  - Checks the expected length:
    - 0x01 (set N): L must be 2.
    - 0x03 (start): L must be 1.
    - 0x04 (matrix load): L must be N·N+1.
    - 0x05 (vector load): L must be N+1.
  - Unknown CMD, length mismatch, or N = 0 on 0x03/0x04/0x05 raises frame_error and goes to IDLE.
  - Otherwise goes to PAYLOAD, or to END if L = 1.
- PAYLOAD for CMD 0x01:
  - Byte must satisfy 1 ≤ value ≤ MAX_N.
  - If valid, it is stored into internal n_reg at END acceptance and N_register_enable pulses at that time, with data_out = value.
  - If invalid, raises frame_error at END.
- PAYLOAD for CMD 0x04:
  - Byte k (0-based) is pushed to FIFO ((k div N) mod 4)+1.
  - A column counter (0..N−1) and a row counter are used; no divider.
- PAYLOAD for CMD 0x05:
  - Every byte is pushed to FIFO5.
- END:
  - 0xEF completes the frame. CMD 0x03 pulses start_op; CMD 0x01 commits N.
  - Any other byte raises frame_error; no start or N update.
  - Pushes already issued are not retracted. The downstream stage uses frame_error to reset its FIFOs.
- 0xFE inside payload is treated as data.

## Timing
- All outputs are registered.
- Reset values: data_out = 0, all strobes = 0, busy = 0. Internal reset values: state = IDLE, n_reg = 0, counters = 0.
- Latency:
  - Any pulse appears the cycle after the rx_valid edge that caused it.
  - Pulses last exactly one cycle.
  - data_out is held until the next accepted byte.
- rx_valid pulses may arrive back-to-back, every cycle; every one is processed.
- Reset asserted mid-frame:
  - Immediately clears state, counters and outputs.
  - Clears n_reg to 0, so loads are refused until a new 0x01 frame is received.
- busy:
  - Rises the cycle after 0xFE is accepted.
  - Falls the cycle after the END byte or the error byte is accepted.
- Counter widths are sized for MAX_N·MAX_N+1.

## Test plan
- Set N: FE 02 01 03 EF. Expect:
  - L_register_enable with data_out = 02.
  - N_register_enable with data_out = 03 one cycle after EF.
  - No error.
- Matrix load with N = 3: FE 0A 04 then bytes 11..19, then EF, back-to-back. Expect:
  - push_FIFO = 00001 for 11–13, 00010 for 14–16, 00100 for 17–19.
  - No error.
- Vector load followed by start: FE 04 05 A1 A2 A3 EF, then FE 01 03 EF. Expect:
  - Three pushes on bit4 with data_out = A1, A2, A3.
  - A start_op pulse one cycle after the second EF.
- Errors:
  - FE 03 01 03 EF (length mismatch): frame_error at CMD, no N update.
  - FE 02 01 09 EF with MAX_N = 8: frame_error.
  - Bad terminator FE 01 03 AA: frame_error, no start_op.
- Reset: assert reset after the 5th payload byte of a matrix load. Expect:
  - Outputs are 0 immediately.
  - A subsequent FE 01 03 EF gives frame_error at CMD, because n_reg = 0.
- Stray bytes 00 EF 55 in IDLE: no outputs, busy stays 0.
